// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670 to RGB332 capture path.
package cam_pkg;

  localparam int unsigned IMG_W_DEF = 160;
  localparam int unsigned IMG_H_DEF = 120;

  typedef enum logic [2:0] {
    WaitVs,
    WaitStart,
    Frame,
    FrameHi,
    ByteLo
  } cam_state_e;

  // hi = RRRRRGGG, lo = GGGBBBBB; keep the top bits of each colour.
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_capture_rgb332_if.sv
// Camera pin bundle plus frame-buffer write port of the capture front end.
interface cam_capture_rgb332_if #(
  parameter int unsigned AW = 15
);

  logic          CAM_pclk;
  logic          CAM_vsync;
  logic          CAM_href;
  logic [7:0]    CAM_px_data;
  logic [AW-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          px_wr;

  modport master (
    input  CAM_pclk,
    input  CAM_vsync,
    input  CAM_href,
    input  CAM_px_data,
    output mem_px_addr,
    output mem_px_data,
    output px_wr
  );

  modport slave (
    output CAM_pclk,
    output CAM_vsync,
    output CAM_href,
    output CAM_px_data,
    input  mem_px_addr,
    input  mem_px_data,
    input  px_wr
  );

endinterface

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses; level output is delayed
// one extra stage so it lines up with the pulses.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q, rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign level = s3_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/cam_capture_rgb332.sv
// OV7670 capture: oversamples the camera pins, packs RGB565 byte pairs into RGB332
// and writes them to a linear IMG_W x IMG_H frame buffer.
module cam_capture_rgb332
  import cam_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned AW    = 15
) (
  input  logic                clk,
  input  logic                rst,
  cam_capture_rgb332_if.master cam,
  output logic                frame_done,
  output logic                err_sticky
);

  localparam int unsigned CW = $clog2(IMG_W + 1);
  localparam int unsigned LW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] ColLim   = CW'(IMG_W);
  localparam logic [LW-1:0] LineLim  = LW'(IMG_H);
  localparam logic [AW-1:0] LineStep = AW'(IMG_W);

  logic pclk_rise, pclk_fall, pclk_lvl;
  logic href_rise, href_fall, href_lvl;

  cam_sync_edge u_sync_pclk (
    .clk   (clk),
    .rst   (rst),
    .din   (cam.CAM_pclk),
    .level (pclk_lvl),
    .rise  (pclk_rise),
    .fall  (pclk_fall)
  );

  cam_sync_edge u_sync_href (
    .clk   (clk),
    .rst   (rst),
    .din   (cam.CAM_href),
    .level (href_lvl),
    .rise  (href_rise),
    .fall  (href_fall)
  );

  logic unused_edges;
  assign unused_edges = pclk_fall ^ pclk_lvl ^ href_rise;

  // Three stages keep vsync/data aligned with the registered edge pulses.
  logic [8:0] dv_s1_q, dv_s2_q, dv_s3_q;
  logic       vsync_lvl;
  logic [7:0] data_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_s1_q <= '0;
      dv_s2_q <= '0;
      dv_s3_q <= '0;
    end else begin
      dv_s1_q <= {cam.CAM_vsync, cam.CAM_px_data};
      dv_s2_q <= dv_s1_q;
      dv_s3_q <= dv_s2_q;
    end
  end

  assign vsync_lvl = dv_s3_q[8];
  assign data_lvl  = dv_s3_q[7:0];

  cam_state_e    state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          px_wr_q, px_wr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          line_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WaitVs;
      line_q    <= '0;
      col_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      px_wr_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      col_q     <= col_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      px_wr_q   <= px_wr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    col_d     = col_q;
    base_d    = base_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    px_wr_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    line_end  = 1'b0;

    unique case (state_q)
      WaitVs: begin
        if (pclk_rise && vsync_lvl) state_d = WaitStart;
      end
      WaitStart: begin
        if (pclk_rise && !vsync_lvl) begin
          state_d = Frame;
          line_d  = '0;
          col_d   = '0;
          base_d  = '0;
          addr_d  = '0;
        end
      end
      Frame: begin
        if (pclk_rise) begin
          if (vsync_lvl) begin
            done_d  = (line_q != '0);
            state_d = WaitStart;
          end else if (href_lvl) begin
            hi_d    = data_lvl;
            state_d = ByteLo;
          end
        end
      end
      FrameHi, ByteLo: begin
        if ((pclk_rise && vsync_lvl) || href_fall) begin
          // A line ending between the two bytes of a pixel drops the half pixel.
          line_end = 1'b1;
          err_d    = err_q | (state_q == ByteLo);
          if (pclk_rise && vsync_lvl) begin
            done_d  = 1'b1;
            state_d = WaitStart;
          end else begin
            state_d = Frame;
          end
        end else if (pclk_rise && href_lvl) begin
          if (state_q == FrameHi) begin
            hi_d    = data_lvl;
            state_d = ByteLo;
          end else begin
            state_d = FrameHi;
            if (col_q < ColLim && line_q < LineLim) begin
              px_wr_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = rgb565_to_332(hi_q, data_lvl);
              addr_d    = addr_q + 1'b1;
            end
            if (col_q < ColLim) col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = WaitVs;
    endcase

    if (line_end) begin
      col_d = '0;
      if (line_q < LineLim) begin
        line_d = line_q + 1'b1;
        base_d = base_q + LineStep;
        addr_d = base_q + LineStep;
      end
    end
  end

  assign cam.mem_px_addr = wr_addr_q;
  assign cam.mem_px_data = wr_data_q;
  assign cam.px_wr       = px_wr_q;
  assign frame_done      = done_q;
  assign err_sticky      = err_q;

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Directed bench for cam_capture_rgb332 using a reduced 8x6 frame.
module tb_cam_capture_rgb332;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned AW = 15;

  logic clk;
  logic rst;
  logic frame_done;
  logic err_sticky;

  cam_capture_rgb332_if #(.AW(AW)) cam_bus ();

  cam_capture_rgb332 #(
    .IMG_W (W),
    .IMG_H (H),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cam        (cam_bus),
    .frame_done (frame_done),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned fd_cnt   = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (cam_bus.px_wr === 1'b1) begin
      wr_addr.push_back(32'(cam_bus.mem_px_addr));
      wr_data.push_back(32'(cam_bus.mem_px_data));
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    fd_cnt = 0;
  endtask

  task automatic idle_pclk(input int n);
    for (int i = 0; i < n; i++) begin
      cam_bus.CAM_pclk = 1'b1;
      tick(2);
      cam_bus.CAM_pclk = 1'b0;
      tick(2);
    end
  endtask

  task automatic send_bytes(input int n, input logic [7:0] hi, input logic [7:0] lo);
    for (int i = 0; i < n; i++) begin
      cam_bus.CAM_pclk    = 1'b0;
      cam_bus.CAM_px_data = (i % 2 == 0) ? hi : lo;
      tick(2);
      cam_bus.CAM_pclk = 1'b1;
      tick(2);
    end
  endtask

  task automatic end_line();
    cam_bus.CAM_pclk = 1'b0;
    cam_bus.CAM_href = 1'b0;
    tick(2);
    idle_pclk(2);
  endtask

  task automatic send_line(input int n, input logic [7:0] hi, input logic [7:0] lo);
    cam_bus.CAM_href = 1'b1;
    send_bytes(n, hi, lo);
    end_line();
  endtask

  task automatic vsync_pulse();
    cam_bus.CAM_vsync = 1'b1;
    idle_pclk(3);
    cam_bus.CAM_vsync = 1'b0;
    idle_pclk(3);
  endtask

  function automatic int unsigned count_addr_bad();
    int unsigned bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] !== 32'(i)) bad++;
    return bad;
  endfunction

  function automatic int unsigned count_data_bad(input logic [31:0] exp);
    int unsigned bad = 0;
    foreach (wr_data[i]) if (wr_data[i] !== exp) bad++;
    return bad;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst                 = 1'b1;
    cam_bus.CAM_pclk    = 1'b0;
    cam_bus.CAM_vsync   = 1'b0;
    cam_bus.CAM_href    = 1'b1;
    cam_bus.CAM_px_data = 8'hE0;

    // Reset held while the camera streams.
    idle_pclk(10);
    @(negedge clk);
    check_eq("rst_addr", 32'(cam_bus.mem_px_addr), 32'd0);
    check_eq("rst_data", 32'(cam_bus.mem_px_data), 32'd0);
    check_eq("rst_wr", 32'(cam_bus.px_wr), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_err", 32'(err_sticky), 32'd0);
    check_eq("rst_wr_cnt", wr_addr.size(), 32'd0);
    tick(1);
    cam_bus.CAM_href = 1'b0;
    idle_pclk(2);
    rst = 1'b0;
    tick(2);
    send_line(16, 8'hE0, 8'hE0);
    send_line(16, 8'hE0, 8'hE0);
    check_eq("pre_vsync_wr_cnt", wr_addr.size(), 32'd0);
    vsync_pulse();

    // Full frame.
    clear_log();
    for (int l = 0; l < int'(H); l++) send_line(16, 8'hE0, 8'hE0);
    vsync_pulse();
    check_eq("full_wr_cnt", wr_addr.size(), 32'd48);
    check_eq("full_addr_order", count_addr_bad(), 32'd0);
    check_eq("full_data", count_data_bad(32'hE0), 32'd0);
    check_eq("full_last_addr", wr_addr[wr_addr.size()-1], 32'd47);
    check_eq("full_done_cnt", fd_cnt, 32'd1);
    check_eq("full_err", 32'(err_sticky), 32'd0);

    // Conversion.
    clear_log();
    cam_bus.CAM_href = 1'b1;
    send_bytes(2, 8'hF8, 8'h1F);
    send_bytes(2, 8'h07, 8'hE0);
    end_line();
    vsync_pulse();
    check_eq("conv_wr_cnt", wr_addr.size(), 32'd2);
    check_eq("conv_px0", wr_data[0], 32'hE3);
    check_eq("conv_px1", wr_data[1], 32'h1C);
    check_eq("conv_addr1", wr_addr[1], 32'd1);
    check_eq("conv_done_cnt", fd_cnt, 32'd1);

    // Long lines and extra lines are dropped silently.
    clear_log();
    for (int l = 0; l < int'(H) + 2; l++) send_line(int'(2 * W) + 4, 8'hF8, 8'h1F);
    vsync_pulse();
    check_eq("long_wr_cnt", wr_addr.size(), 32'd48);
    check_eq("long_last_addr", wr_addr[wr_addr.size()-1], 32'd47);
    check_eq("long_addr_order", count_addr_bad(), 32'd0);
    check_eq("long_err", 32'(err_sticky), 32'd0);

    // Odd byte count on the first line.
    clear_log();
    send_line(int'(2 * W) + 1, 8'h07, 8'hE0);
    send_line(int'(2 * W), 8'h07, 8'hE0);
    check_eq("odd_wr_cnt", wr_addr.size(), 32'd16);
    check_eq("odd_line1_start", wr_addr[8], 32'd8);
    check_eq("odd_line0_last", wr_addr[7], 32'd7);
    check_eq("odd_err", 32'(err_sticky), 32'd1);
    vsync_pulse();

    // Reset in the middle of a frame.
    send_line(16, 8'hE0, 8'hE0);
    send_line(16, 8'hE0, 8'hE0);
    cam_bus.CAM_href = 1'b1;
    send_bytes(6, 8'hE0, 8'hE0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_wr", 32'(cam_bus.px_wr), 32'd0);
    check_eq("midrst_err", 32'(err_sticky), 32'd0);
    check_eq("midrst_addr", 32'(cam_bus.mem_px_addr), 32'd0);
    tick(2);
    rst = 1'b0;
    clear_log();
    send_bytes(10, 8'hE0, 8'hE0);
    end_line();
    send_line(16, 8'hE0, 8'hE0);
    vsync_pulse();
    check_eq("midrst_wr_cnt", wr_addr.size(), 32'd0);
    check_eq("midrst_done_cnt", fd_cnt, 32'd0);
    clear_log();
    for (int l = 0; l < int'(H); l++) send_line(16, 8'hF8, 8'h1F);
    vsync_pulse();
    check_eq("resync_wr_cnt", wr_addr.size(), 32'd48);
    check_eq("resync_addr_order", count_addr_bad(), 32'd0);
    check_eq("resync_data", count_data_bad(32'hE3), 32'd0);
    check_eq("resync_done_cnt", fd_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_capture_rgb332.md
Name: cam_capture_rgb332

Overview:
- Camera capture front end between the OV7670 pins and the frame-buffer write port.
- Oversamples CAM_pclk/CAM_vsync/CAM_href/CAM_px_data in the system clock domain and assembles byte pairs (RGB565) into RGB332 pixels.
- Writes each pixel to a linear 160x120 buffer address with a one-cycle write strobe.
- Signals end of frame and protocol errors to the top level.

Parameters:
- IMG_W, 160, pixels per line stored.
- IMG_H, 120, lines per frame stored.
- AW, 15, address width (IMG_W*IMG_H-1 must fit).

Ports:
- clk  in  1  system clock, 100 MHz, at least 4x CAM_pclk.
- rst  in  1  asynchronous reset, active-high.
- CAM_pclk  in  1  camera pixel clock; sampled as data, not used as a clock.
- CAM_vsync  in  1  frame sync; high = vertical blanking.
- CAM_href  in  1  line valid, high during active bytes.
- CAM_px_data  in  8  camera byte, valid at CAM_pclk rising edge.
- mem_px_addr  out  AW  buffer write address.
- mem_px_data  out  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
- px_wr  out  1  write strobe, one clk wide.
- frame_done  out  1  one-clk pulse when a captured frame closes.
- err_sticky  out  1  protocol error seen; cleared only by rst.

Behaviour:
- Reset values: mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, err_sticky=0, FSM=WAIT_VS, all synchronizer flops=0.
- Synchronization:
  - 2-flop synchronizer on pclk, vsync, href and data (all 11 bits delayed equally).
  - pclk_rise = sync_pclk & ~sync_pclk_d.
  - All camera events are evaluated only on pclk_rise, except href falling, which is checked every clk.
- FSM states:
  - WAIT_VS: wait for vsync=1 at a pclk_rise, then go to WAIT_START. Capture never starts mid-frame.
  - WAIT_START: vsync=0 at a pclk_rise -> FRAME; clear line=0, col=0, addr=0.
  - FRAME: href=1 at a pclk_rise -> latch byte as hi, go to BYTE_LO. vsync=1 -> pulse frame_done, go to WAIT_START.
  - BYTE_LO: href=1 at pclk_rise -> form pixel, go to FRAME_HI.
  - FRAME_HI: href=1 at pclk_rise -> latch hi byte, go to BYTE_LO.
  - FRAME_HI and BYTE_LO, on href falling edge: line<=line+1 (saturating at IMG_H), col<=0, go to FRAME. If the falling edge occurs in BYTE_LO (odd byte count), discard the half pixel and set err_sticky.
  - FRAME_HI and BYTE_LO, vsync=1: treated as FRAME plus a line end; sets err_sticky if in BYTE_LO.
- Pixel formation: hi=RRRRRGGG, lo=GGGBBBBB; mem_px_data = {hi[7:5], hi[2:0], lo[4:3]}.
- Write rules:
  - px_wr asserts the clk after the lo-byte pclk_rise, only if col<IMG_W and line<IMG_H.
  - mem_px_addr = line*IMG_W + col, maintained as a running counter (no multiplier).
  - col increments on every pixel, saturating at IMG_W.
  - Latency: lo byte at pin -> px_wr = 4 clk (2 sync + edge detect + register).
- Overflow: pixels with col>=IMG_W, or lines with line>=IMG_H, are dropped silently (no err). A short line or short frame is accepted as-is.
- frame_done fires only if at least one line was seen since WAIT_START.
- rst mid-frame: all outputs clear immediately; the block resynchronizes via WAIT_VS, and the partial frame is never written.

Decomposition:
- Shared package (cam_pkg):
  - IMG_W/IMG_H defaults.
  - RGB565->RGB332 bit-slice function.
  - FSM state encoding (WAIT_VS, WAIT_START, FRAME, FRAME_HI, BYTE_LO).
- Sub-module cam_sync_edge: 2-flop synchronizer plus rise/fall detect, instantiated for pclk/href (data and vsync use plain sync).
- Everything else lives in cam_capture_rgb332.

Test Plan:
- Reset:
  - Stimulus: rst=1 with toggling pclk and href=1.
  - Required: px_wr never asserts; all outputs 0; after release, no writes occur until a vsync 1->0 transition is seen.
- Full frame:
  - Stimulus: vsync pulse, then 120 lines of 320 bytes of 8'hE0, pclk 25 MHz.
  - Required: exactly 19200 px_wr; data 8'hE0 throughout; addresses 0..19199 in order; one frame_done on the next vsync rise.
- Conversion:
  - Stimulus: byte pair 8'hF8,8'h1F -> then 8'h07,8'hE0.
  - Required: first pixel 8'hE3; second pixel 8'h1C.
- Long lines and frames:
  - Stimulus: 324 bytes per line, 124 lines.
  - Required: still 19200 writes; last address 19199; err_sticky=0.
- Odd byte count:
  - Stimulus: one line of 321 bytes.
  - Required: 160 writes for that line; err_sticky=1; next line starts at address line*160.
- Mid-frame reset:
  - Stimulus: assert rst at line 50, release, continue stimulus.
  - Required: no writes until the next vsync cycle; the following frame is complete at addresses 0..19199.
